// File: rtl/preproc_frame_scheduler_if.sv
// Stream-side signal bundle for the frame scheduler.
// The scheduler observes input acceptance and output handshakes, and
// returns the per-beat frame tags.
//   in_fire    : input beat accepted by the stage (tvalid && tready)
//   out_valid  : stage output tvalid
//   out_ready  : downstream output tready
//   out_tuser  : SOF tag, high with the first output beat of a frame
//   out_tlast  : EOL tag, high with the last beat of each line
//   out_eof    : EOF tag, high with the final beat of the frame
// The master modport is the scheduler. The slave modport is the datapath or bench side.
interface preproc_frame_scheduler_if;
    logic in_fire;
    logic out_valid;
    logic out_ready;
    logic out_tuser;
    logic out_tlast;
    logic out_eof;

    modport master (
        input  in_fire, out_valid, out_ready,
        output out_tuser, out_tlast, out_eof
    );

    modport slave (
        output in_fire, out_valid, out_ready,
        input  out_tuser, out_tlast, out_eof
    );
endinterface

// File: rtl/preproc_frame_scheduler.sv
// Frame-level sequencer for the RGB min/max normalisation stage.
// It issues the per-frame min/max clear and gates the stage enable.
// It counts accepted input beats and delivered output beats.
// It tags the output stream with SOF/EOL/EOF and reports done, abort and timeout.
// It can run frames back to back.
// Ports:
//   clk, rst        : clock, async active-high reset
//   start           : begin a frame (sampled in IDLE only)
//   abort           : cancel the current frame (ignored in IDLE)
//   continuous      : sampled in DONE, 1 -> next frame starts immediately
//   bus             : stream handshake inputs and frame tag outputs
//   pp_enable       : stage enable (high in STREAM only)
//   pp_frame_start  : stage min/max clear (high in CLEAR only)
//   busy            : any state other than IDLE
//   done, aborted   : single-cycle completion / abort pulses
//   timeout_err     : sticky watchdog flag, cleared by the next accepted start
//   in_count        : input beats accepted this frame
//   out_count       : output beats delivered this frame
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | waiting for start
// S_CLEAR  | one cycle of pp_frame_start; counters were just zeroed
// S_STREAM | stage enabled, accepting input beats
// S_DRAIN  | all inputs taken, waiting for the remaining output beats
// S_DONE   | done pulse, then restart or return to idle
module preproc_frame_scheduler #(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int NPIX          = WIDTH * HEIGHT,
    localparam int CW            = $clog2(NPIX + 1),
    localparam int TW            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      continuous,
    preproc_frame_scheduler_if.master bus,
    output logic                      pp_enable,
    output logic                      pp_frame_start,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic                      timeout_err,
    output logic [CW-1:0]             in_count,
    output logic [CW-1:0]             out_count
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [CW-1:0] NPIX_C     = CW'(NPIX);
    localparam logic [CW-1:0] NPIX_M1    = CW'(NPIX - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);
    localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STALL_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [TW-1:0] stall_cnt;

    logic out_fire;
    logic any_fire;
    logic counting;
    logic stall_tc;
    logic clr_cnt;
    logic clr_terr;
    logic set_terr;
    logic set_abort;

    assign out_fire = bus.out_valid && bus.out_ready;
    assign any_fire = bus.in_fire || out_fire;
    assign counting = (state == S_STREAM) || (state == S_DRAIN);
    // Fires on the idle cycle that would bring the stall count to TIMEOUT_CYCLES.
    assign stall_tc = counting && !any_fire && (stall_cnt == STALL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        clr_cnt        = 1'b0;
        clr_terr       = 1'b0;
        set_terr       = 1'b0;
        set_abort      = 1'b0;
        pp_enable      = (state == S_STREAM);
        pp_frame_start = (state == S_CLEAR);
        busy           = (state != S_IDLE);
        done           = (state == S_DONE);

        if (state != S_IDLE && abort) begin
            state_nxt = S_IDLE;
            set_abort = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_nxt = S_CLEAR;
                        clr_cnt   = 1'b1;
                        clr_terr  = 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_nxt = S_STREAM;
                end
                S_STREAM: begin
                    // Leaving STREAM on the last input beat drops pp_enable at the
                    // same edge, so the stage cannot accept beat NPIX+1.
                    if (bus.in_fire && in_count == NPIX_M1) begin
                        state_nxt = S_DRAIN;
                    end else if (stall_tc) begin
                        state_nxt = S_IDLE;
                        set_terr  = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_count == NPIX_C) begin
                        state_nxt = S_DONE;
                    end else if (stall_tc) begin
                        state_nxt = S_IDLE;
                        set_terr  = 1'b1;
                    end
                end
                S_DONE: begin
                    if (continuous) begin
                        state_nxt = S_CLEAR;
                        clr_cnt   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Beat counters and output position. On an abort cycle, the counters
    // keep their values so the host can see how far the frame got.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_count  <= '0;
            out_count <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
        end else if (clr_cnt) begin
            in_count  <= '0;
            out_count <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
        end else if (counting && !abort) begin
            if (state == S_STREAM && bus.in_fire && in_count != NPIX_C) begin
                in_count <= in_count + 1'b1;
            end
            if (out_fire && out_count != NPIX_C) begin
                out_count <= out_count + 1'b1;
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!counting || any_fire) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            aborted <= set_abort;
            if (clr_terr) begin
                timeout_err <= 1'b0;
            end else if (set_terr) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // The tags are taken straight from the position counters, so they line
    // up with the beat currently on the bus.
    assign bus.out_tuser = bus.out_valid && (x_cnt == '0) && (y_cnt == '0);
    assign bus.out_tlast = bus.out_valid && (x_cnt == X_LAST);
    assign bus.out_eof   = bus.out_valid && (out_count == NPIX_M1);

endmodule
